cpu_ad48_core: RTL and testbench
================================

Name: cpu_ad48_core

Overview:
- Single-cycle 48-bit CPU (AD48 ISA subset): eight 48-bit D registers, internal word-addressed instruction/data memories, CSR file, one vectored interrupt path.
- One instruction retires per clock; CSR-programmable IRQ vector, EPC/CAUSE capture, IRET return.
- Top compute block of the AD48 SoC; only pins are clock, reset and IRQ lines.

Parameters:
- IM_WORDS, 128, instruction memory depth (48-bit words).
- DM_WORDS, 32, data memory depth.
- TRAP_VECTOR, 48'd48, PC loaded on synchronous exception.
- IRQ_LINES, 4, number of interrupt inputs (1..32).
- IRQ_VECTOR, 48'd40, reset value of the IRQ_VECTOR CSR.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- resetn  in  1  synchronous, active-high reset (port keeps the codebase name).
- irq  in  IRQ_LINES  level interrupt requests, sampled every rising edge.

Behaviour:
- Required hierarchy for bench backdoor access: IMEM.mem[], DMEM.mem[], RF_D.regs[0:7]. Signals pc, halt, csr_status, csr_epc, csr_cause, csr_irq_enable, csr_irq_pending, csr_irq_vector, all 48-bit except halt.
- Reset: pc=0, halt=0, all CSRs 0, except csr_irq_vector=IRQ_VECTOR. Registers and memories are not reset.
- Encoding: opcode [47:42]. Fields rd [40:38], rs [37:35], rt [34:32], subop [30:27], imm27 [26:0].
  - SYS=0x00: func [41:38], 0 NOP, 1 HALT, 2 IRET.
  - ALU_R=0x01: rd = rs op rt.
  - ALUI_D=0x02: [41]=1 sign-extends imm27, 0 zero-extends; rd = rs op imm.
  - LD=0x03: rd = DMEM[rs+imm].
  - ST=0x04: DMEM[rs+imm] = rt.
  - BR=0x05: [41]=0 BEQZ, 1 BNZ on rs; target pc+imm (signed).
  - CSR=0x06: func [41:40] 0 RW, 1 RS, 2 RC. Bank [39] must be 0 (D bank). rd [38:36], rs [35:33], addr [11:0].
- ALU subops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (shift amount = operand[5:0]). Arithmetic wraps mod 2^48.
- Memory addresses: low address bits index the array, out-of-range addresses wrap.
- Register writes: every write port targets RF_D.regs. D0 is an ordinary register that stays 0 unless written.
- CSR access: rd receives the old CSR value. RW writes rs, RS ORs rs in, RC clears the rs bits.
  - Addresses: STATUS 0x000, EPC 0x001, CAUSE 0x002, IRQ_ENABLE 0x010, IRQ_PENDING 0x011, IRQ_VECTOR 0x012.
  - Unknown address reads 0 and ignores writes.
- STATUS: bit4 MIE, bit5 MPIE; other bits are plain storage.
- Interrupt pending: pending_eff = csr_irq_pending | irq. Each edge csr_irq_pending <= pending_eff after any CSR write. A same-cycle irq set wins over an RC clear.
- Interrupt take: when !halt && MIE && |(pending_eff & csr_irq_enable), at that edge:
  - the instruction at pc is NOT executed;
  - EPC=pc, CAUSE={1'b1, 41'b0, index[5:0]} (lowest active line);
  - MPIE=MIE, MIE=0, pc=csr_irq_vector.
- IRET: pc=EPC, MIE=MPIE, MPIE=1.
- HALT: halt=1 and pc holds at the HALT address. Only reset clears halt. Interrupts are ignored while halted.
- Default: pc+1.

Optional Feature:
- Macro CPU_AD48_TRAP_ILLEGAL_EN.
- Defined: undefined opcode/func or CSR bank=1 is not executed. Sets EPC=pc, CAUSE={1'b0, ..., 6'd2}, MPIE=MIE, MIE=0, pc=TRAP_VECTOR.
- Undefined: such instructions behave as NOP.

Decomposition:
- Package/include cpu_ad48_pkg holds:
  - opcode, SYS/CSR/ALU func codes and CSR addresses;
  - STATUS bit indices and cause codes;
  - encoder functions for benches (instr_sys, instr_alui_d, instr_csr, pack_imm27, pack_subop, pack_csr_addr).
- Natural sub-module: cpu_ad48_regfile (8x48, 2 read/1 write, instance RF_D).
- Memories are simple arrays in instances IMEM/DMEM.

Test Plan:
- ALUI_D D5 = D5 + 1 from 0, then HALT at 9 -> D5=1, halt=1, pc stays 9.
- Program STATUS=0x13, IRQ_ENABLE=1, IRQ_VECTOR=40, NOP at 6. Pulse irq[0] for one cycle while pc=7 -> next pc=40, EPC=7, CAUSE[47]=1, CAUSE[5:0]=0, MIE=0.
- Handler at 40 does D1=1, CSR RC IRQ_PENDING with D1, then IRET. Execution resumes at 7 -> D5=1, D6=1 (each once), MIE=1, enable[0]=1, pending[0]=0, halt with pc=9.
- irq[1] asserted with enable=0b0001 -> pending[1]=1, no interrupt taken; then set enable bit1 -> taken, CAUSE[5:0]=1.
- LD/ST: store D2=0x123 to DMEM[3], load into D4 -> D4=0x123. BNZ on D4 skips the next instruction.
- With CPU_AD48_TRAP_ILLEGAL_EN: opcode 0x3F at pc=2 -> pc=48, EPC=2, CAUSE=2. Without the macro: pc advances to 3.

Source files
------------

// File: rtl/cpu_ad48_pkg.sv
// AD48 ISA constants, ALU helper and instruction encoders shared by core and benches.
// Latency: n/a (package); backpressure: n/a.
package cpu_ad48_pkg;

    localparam logic [5:0] OP_SYS    = 6'h00;
    localparam logic [5:0] OP_ALU_R  = 6'h01;
    localparam logic [5:0] OP_ALUI_D = 6'h02;
    localparam logic [5:0] OP_LD     = 6'h03;
    localparam logic [5:0] OP_ST     = 6'h04;
    localparam logic [5:0] OP_BR     = 6'h05;
    localparam logic [5:0] OP_CSR    = 6'h06;

    localparam logic [3:0] SYS_NOP  = 4'd0;
    localparam logic [3:0] SYS_HALT = 4'd1;
    localparam logic [3:0] SYS_IRET = 4'd2;

    localparam logic [1:0] CSR_RW = 2'd0;
    localparam logic [1:0] CSR_RS = 2'd1;
    localparam logic [1:0] CSR_RC = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_SHR = 4'd6;

    localparam logic [11:0] CSR_STATUS      = 12'h000;
    localparam logic [11:0] CSR_EPC         = 12'h001;
    localparam logic [11:0] CSR_CAUSE       = 12'h002;
    localparam logic [11:0] CSR_IRQ_ENABLE  = 12'h010;
    localparam logic [11:0] CSR_IRQ_PENDING = 12'h011;
    localparam logic [11:0] CSR_IRQ_VECTOR  = 12'h012;

    localparam int STATUS_MIE  = 4;
    localparam int STATUS_MPIE = 5;

    localparam logic [5:0] CAUSE_ILLEGAL = 6'd2;

    function automatic logic [47:0] alu48(input logic [3:0] subop,
                                          input logic [47:0] a,
                                          input logic [47:0] b);
        logic [47:0] y;
        y = '0;
        case (subop)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SHL: y = a << b[5:0];
            ALU_SHR: y = a >> b[5:0];
            default: y = '0;
        endcase
        return y;
    endfunction

    function automatic logic alu_legal(input logic [3:0] subop);
        return subop <= ALU_SHR;
    endfunction

    function automatic logic [5:0] lowest_set(input logic [47:0] v);
        logic [5:0] idx;
        idx = '0;
        for (int i = 47; i >= 0; i--) begin
            if (v[i]) idx = 6'(i);
        end
        return idx;
    endfunction

    function automatic logic [47:0] pack_imm27(input logic [26:0] imm);
        return {21'b0, imm};
    endfunction

    function automatic logic [47:0] pack_subop(input logic [3:0] subop);
        return {17'b0, subop, 27'b0};
    endfunction

    function automatic logic [47:0] pack_csr_addr(input logic [11:0] addr);
        return {36'b0, addr};
    endfunction

    function automatic logic [47:0] instr_sys(input logic [3:0] func);
        return {OP_SYS, func, 38'b0};
    endfunction

    function automatic logic [47:0] instr_rri(input logic [5:0] op, input logic b41,
                                              input logic [2:0] rd, input logic [2:0] rs,
                                              input logic [2:0] rt, input logic [3:0] subop,
                                              input logic [26:0] imm);
        return {op, b41, rd, rs, rt, 1'b0, 31'b0} | pack_subop(subop) | pack_imm27(imm);
    endfunction

    function automatic logic [47:0] instr_alui_d(input logic sx, input logic [2:0] rd,
                                                 input logic [2:0] rs, input logic [3:0] subop,
                                                 input logic [26:0] imm);
        return instr_rri(OP_ALUI_D, sx, rd, rs, 3'd0, subop, imm);
    endfunction

    function automatic logic [47:0] instr_csr(input logic [1:0] func, input logic [2:0] rd,
                                              input logic [2:0] rs, input logic [11:0] addr);
        return {OP_CSR, func, 1'b0, rd, rs, 33'b0} | pack_csr_addr(addr);
    endfunction

endpackage

// File: rtl/cpu_ad48_mem.sv
// Word-addressed 48-bit array: combinational read, write on rising clk.
// Latency: read 0 cycles, write visible next cycle; backpressure: none.
module cpu_ad48_mem #(
    parameter int WORDS = 32,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [47:0]   i_wdat,
    input  logic [AW-1:0] i_raddr,
    output logic [47:0]   o_rdat
);

    logic [47:0] mem [0:WORDS-1];

    always_ff @(posedge clk) begin
        if (i_we) mem[i_waddr] <= i_wdat;
    end

    assign o_rdat = mem[i_raddr];

endmodule

// File: rtl/cpu_ad48_regfile.sv
// 8x48 D register file, two combinational read ports and one write port.
// Latency: read 0 cycles, write visible next cycle; backpressure: none.
module cpu_ad48_regfile (
    input  logic        clk,
    input  logic        i_we,
    input  logic [2:0]  i_waddr,
    input  logic [47:0] i_wdat,
    input  logic [2:0]  i_raddr_a,
    output logic [47:0] o_rdat_a,
    input  logic [2:0]  i_raddr_b,
    output logic [47:0] o_rdat_b
);

    logic [47:0] regs [0:7];

    always_ff @(posedge clk) begin
        if (i_we) regs[i_waddr] <= i_wdat;
    end

    assign o_rdat_a = regs[i_raddr_a];
    assign o_rdat_b = regs[i_raddr_b];

endmodule

// File: rtl/cpu_ad48_core.sv
// Single-cycle AD48 core with CSRs and vectored IRQ; CPU_AD48_TRAP_ILLEGAL_EN traps illegal ops.
// Latency: one instruction retires per clk; backpressure: none (IRQs are level, latched in pending).
module cpu_ad48_core
    import cpu_ad48_pkg::*;
#(
    parameter int          IM_WORDS    = 128,
    parameter int          DM_WORDS    = 32,
    parameter logic [47:0] TRAP_VECTOR = 48'd48,
    parameter int          IRQ_LINES   = 4,
    parameter logic [47:0] IRQ_VECTOR  = 48'd40
) (
    input logic                 clk,
    input logic                 resetn,
    input logic [IRQ_LINES-1:0] irq
);

    localparam int IM_AW = $clog2(IM_WORDS);
    localparam int DM_AW = $clog2(DM_WORDS);
`ifdef CPU_AD48_TRAP_ILLEGAL_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [47:0] pc;
    logic        halt;
    logic [47:0] csr_status, csr_epc, csr_cause;
    logic [47:0] csr_irq_enable, csr_irq_pending, csr_irq_vector;

    logic [47:0] w_instr, w_rd_a, w_rd_b, w_imm_s, w_imm_z, w_alu_b, w_alu_y;
    logic [47:0] w_maddr, w_dm_rdat, w_csr_old, w_csr_wdat, w_pc_next, w_rf_wdat;
    logic [47:0] w_irq_ext, w_pend_eff, w_irq_hit, w_pend_next;
    logic [5:0]  w_op;
    logic [11:0] w_csr_addr;
    logic [2:0]  w_ra, w_wa;
    logic        w_rf_we, w_dm_we, w_csr_we, w_halt_set, w_iret, w_illegal;
    logic        w_take, w_trap, w_exec;

    assign w_op       = w_instr[47:42];
    assign w_csr_addr = w_instr[11:0];
    assign w_imm_s    = {{21{w_instr[26]}}, w_instr[26:0]};
    assign w_imm_z    = {21'b0, w_instr[26:0]};
    assign w_ra       = (w_op == OP_CSR) ? w_instr[35:33] : w_instr[37:35];
    assign w_wa       = (w_op == OP_CSR) ? w_instr[38:36] : w_instr[40:38];
    assign w_alu_b    = (w_op == OP_ALU_R) ? w_rd_b : (w_instr[41] ? w_imm_s : w_imm_z);
    assign w_alu_y    = alu48(w_instr[30:27], w_rd_a, w_alu_b);
    assign w_maddr    = w_rd_a + w_imm_s;

    cpu_ad48_mem #(.WORDS(IM_WORDS)) IMEM (
        .clk     (clk),
        .i_we    (1'b0),
        .i_waddr ({IM_AW{1'b0}}),
        .i_wdat  (48'd0),
        .i_raddr (pc[IM_AW-1:0]),
        .o_rdat  (w_instr)
    );

    cpu_ad48_mem #(.WORDS(DM_WORDS)) DMEM (
        .clk     (clk),
        .i_we    (w_dm_we && w_exec),
        .i_waddr (w_maddr[DM_AW-1:0]),
        .i_wdat  (w_rd_b),
        .i_raddr (w_maddr[DM_AW-1:0]),
        .o_rdat  (w_dm_rdat)
    );

    cpu_ad48_regfile RF_D (
        .clk       (clk),
        .i_we      (w_rf_we && w_exec),
        .i_waddr   (w_wa),
        .i_wdat    (w_rf_wdat),
        .i_raddr_a (w_ra),
        .o_rdat_a  (w_rd_a),
        .i_raddr_b (w_instr[34:32]),
        .o_rdat_b  (w_rd_b)
    );

    always_comb begin
        w_csr_old = '0;
        case (w_csr_addr)
            CSR_STATUS:      w_csr_old = csr_status;
            CSR_EPC:         w_csr_old = csr_epc;
            CSR_CAUSE:       w_csr_old = csr_cause;
            CSR_IRQ_ENABLE:  w_csr_old = csr_irq_enable;
            CSR_IRQ_PENDING: w_csr_old = csr_irq_pending;
            CSR_IRQ_VECTOR:  w_csr_old = csr_irq_vector;
            default:         w_csr_old = '0;
        endcase
    end

    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_wdat  = w_alu_y;
        w_dm_we    = 1'b0;
        w_csr_we   = 1'b0;
        w_csr_wdat = w_rd_a;
        w_pc_next  = pc + 48'd1;
        w_halt_set = 1'b0;
        w_iret     = 1'b0;
        w_illegal  = 1'b0;
        case (w_op)
            OP_SYS: begin
                case (w_instr[41:38])
                    SYS_NOP:  ;
                    SYS_HALT: begin w_halt_set = 1'b1; w_pc_next = pc; end
                    SYS_IRET: begin w_iret = 1'b1; w_pc_next = csr_epc; end
                    default:  w_illegal = 1'b1;
                endcase
            end
            OP_ALU_R, OP_ALUI_D: begin
                if (alu_legal(w_instr[30:27])) w_rf_we = 1'b1;
                else                           w_illegal = 1'b1;
            end
            OP_LD: begin
                w_rf_we   = 1'b1;
                w_rf_wdat = w_dm_rdat;
            end
            OP_ST: w_dm_we = 1'b1;
            OP_BR: begin
                if ((w_rd_a != 48'd0) == w_instr[41]) w_pc_next = pc + w_imm_s;
            end
            OP_CSR: begin
                w_rf_wdat = w_csr_old;
                case (w_instr[41:40])
                    CSR_RW:  w_csr_wdat = w_rd_a;
                    CSR_RS:  w_csr_wdat = w_csr_old | w_rd_a;
                    CSR_RC:  w_csr_wdat = w_csr_old & ~w_rd_a;
                    default: w_illegal = 1'b1;
                endcase
                if (w_instr[39]) w_illegal = 1'b1;
                if (!w_illegal) begin
                    w_rf_we  = 1'b1;
                    w_csr_we = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Pending keeps accumulating every edge; irq is ORed last so it beats an RC clear.
    assign w_irq_ext   = 48'(irq);
    assign w_pend_eff  = csr_irq_pending | w_irq_ext;
    assign w_irq_hit   = w_pend_eff & csr_irq_enable;
    assign w_take      = !halt && csr_status[STATUS_MIE] && (|w_irq_hit);
    assign w_trap      = TRAP_EN && !halt && !w_take && w_illegal;
    assign w_exec      = !halt && !w_take && !w_trap;
    assign w_pend_next = ((w_csr_we && w_exec && w_csr_addr == CSR_IRQ_PENDING) ?
                          w_csr_wdat : csr_irq_pending) | w_irq_ext;

    always_ff @(posedge clk) begin
        if (resetn) begin
            pc              <= '0;
            halt            <= 1'b0;
            csr_status      <= '0;
            csr_epc         <= '0;
            csr_cause       <= '0;
            csr_irq_enable  <= '0;
            csr_irq_pending <= '0;
            csr_irq_vector  <= IRQ_VECTOR;
        end else begin
            csr_irq_pending <= w_pend_next;
            if (w_take) begin
                csr_epc                 <= pc;
                csr_cause               <= {1'b1, 41'b0, lowest_set(w_irq_hit)};
                csr_status[STATUS_MPIE] <= csr_status[STATUS_MIE];
                csr_status[STATUS_MIE]  <= 1'b0;
                pc                      <= csr_irq_vector;
            end else if (w_trap) begin
                csr_epc                 <= pc;
                csr_cause               <= {42'b0, CAUSE_ILLEGAL};
                csr_status[STATUS_MPIE] <= csr_status[STATUS_MIE];
                csr_status[STATUS_MIE]  <= 1'b0;
                pc                      <= TRAP_VECTOR;
            end else if (w_exec) begin
                pc <= w_pc_next;
                if (w_halt_set) halt <= 1'b1;
                if (w_iret) begin
                    csr_status[STATUS_MIE]  <= csr_status[STATUS_MPIE];
                    csr_status[STATUS_MPIE] <= 1'b1;
                end
                if (w_csr_we) begin
                    case (w_csr_addr)
                        CSR_STATUS:     csr_status     <= w_csr_wdat;
                        CSR_EPC:        csr_epc        <= w_csr_wdat;
                        CSR_CAUSE:      csr_cause      <= w_csr_wdat;
                        CSR_IRQ_ENABLE: csr_irq_enable <= w_csr_wdat;
                        CSR_IRQ_VECTOR: csr_irq_vector <= w_csr_wdat;
                        default:        ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_ad48_core.sv
// Directed bench for cpu_ad48_core: programs loaded by backdoor, results checked via a scoreboard queue.
// Latency: n/a; backpressure: n/a.
module tb_cpu_ad48_core;
    import cpu_ad48_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [3:0] irq = 4'd0;

    int total  = 0;
    int passed = 0;

    string       tag_q[$];
    logic [47:0] exp_q[$];

    cpu_ad48_core dut (
        .clk    (clk),
        .resetn (resetn),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic expect_v(input string tag, input logic [47:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_obs(input logic [47:0] obs);
        string       t;
        logic [47:0] e;
        total++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty observed=0x%h expected=<none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) passed++;
            else $error("FAIL %s observed=0x%h expected=0x%h", t, obs, e);
        end
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        expect_v(tag, exp);
        check_obs(obs);
    endtask

    task automatic load(input int a, input logic [47:0] w);
        dut.IMEM.mem[a] = w;
    endtask

    task automatic start_reset();
        resetn = 1'b1;
        irq    = 4'd0;
        @(negedge clk);
        for (int i = 0; i < 128; i++) dut.IMEM.mem[i] = 48'd0;
        for (int i = 0; i < 32; i++)  dut.DMEM.mem[i] = 48'd0;
        for (int i = 0; i < 8; i++)   dut.RF_D.regs[i] = 48'd0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
    endtask

    task automatic wait_pc(input logic [47:0] target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dut.pc == target) break;
        end
        chk("pc_reached", dut.pc, target);
    endtask

    task automatic wait_halt(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dut.halt) break;
        end
        chk("halt_reached", {47'b0, dut.halt}, 48'd1);
    endtask

    initial begin
        logic [47:0] illegal_w;
        illegal_w = {6'h3F, 42'd0};

        // Program A: CSR setup, IRQ0 taken at pc=7, handler clears pending and returns.
        start_reset();
        load(0, instr_alui_d(1'b0, 3'd1, 3'd0, ALU_ADD, 27'h13));
        load(1, instr_csr(CSR_RW, 3'd7, 3'd1, CSR_STATUS));
        load(2, instr_alui_d(1'b0, 3'd1, 3'd0, ALU_ADD, 27'd1));
        load(3, instr_csr(CSR_RW, 3'd7, 3'd1, CSR_IRQ_ENABLE));
        load(4, instr_alui_d(1'b0, 3'd1, 3'd0, ALU_ADD, 27'd40));
        load(5, instr_csr(CSR_RW, 3'd7, 3'd1, CSR_IRQ_VECTOR));
        load(6, instr_sys(SYS_NOP));
        load(7, instr_alui_d(1'b0, 3'd5, 3'd5, ALU_ADD, 27'd1));
        load(8, instr_alui_d(1'b0, 3'd6, 3'd6, ALU_ADD, 27'd1));
        load(9, instr_sys(SYS_HALT));
        load(40, instr_alui_d(1'b0, 3'd1, 3'd0, ALU_ADD, 27'd1));
        load(41, instr_csr(CSR_RC, 3'd7, 3'd1, CSR_IRQ_PENDING));
        load(42, instr_sys(SYS_IRET));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", dut.pc, 48'd0);
        chk("rst_halt", {47'b0, dut.halt}, 48'd0);
        chk("rst_status", dut.csr_status, 48'd0);
        chk("rst_epc", dut.csr_epc, 48'd0);
        chk("rst_cause", dut.csr_cause, 48'd0);
        chk("rst_enable", dut.csr_irq_enable, 48'd0);
        chk("rst_pending", dut.csr_irq_pending, 48'd0);
        chk("rst_vector", dut.csr_irq_vector, 48'd40);
        resetn = 1'b0;

        wait_pc(48'd7, 40);
        irq = 4'b0001;
        @(negedge clk);
        irq = 4'b0000;
        chk("irq0_pc", dut.pc, 48'd40);
        chk("irq0_epc", dut.csr_epc, 48'd7);
        chk("irq0_cause", dut.csr_cause, 48'h8000_0000_0000);
        chk("irq0_mie", {47'b0, dut.csr_status[STATUS_MIE]}, 48'd0);
        chk("irq0_d5_not_run", dut.RF_D.regs[5], 48'd0);
        wait_halt(60);
        chk("a_d5", dut.RF_D.regs[5], 48'd1);
        chk("a_d6", dut.RF_D.regs[6], 48'd1);
        chk("a_mie", {47'b0, dut.csr_status[STATUS_MIE]}, 48'd1);
        chk("a_enable", dut.csr_irq_enable, 48'd1);
        chk("a_pending", dut.csr_irq_pending, 48'd0);
        chk("a_pc", dut.pc, 48'd9);
        repeat (3) @(negedge clk);
        chk("a_pc_held", dut.pc, 48'd9);

        // Program B: IRQ1 pends while masked, taken once its enable bit is set by RS.
        start_reset();
        load(0, instr_alui_d(1'b0, 3'd1, 3'd0, ALU_ADD, 27'h10));
        load(1, instr_csr(CSR_RW, 3'd7, 3'd1, CSR_STATUS));
        load(2, instr_alui_d(1'b0, 3'd1, 3'd0, ALU_ADD, 27'd1));
        load(3, instr_csr(CSR_RW, 3'd7, 3'd1, CSR_IRQ_ENABLE));
        load(4, instr_alui_d(1'b0, 3'd2, 3'd0, ALU_ADD, 27'd2));
        load(5, instr_csr(CSR_RS, 3'd7, 3'd2, CSR_IRQ_ENABLE));
        load(6, instr_sys(SYS_NOP));
        load(40, instr_sys(SYS_HALT));
        release_reset();
        irq = 4'b0010;
        wait_pc(48'd5, 20);
        chk("b_pending_masked", dut.csr_irq_pending, 48'd2);
        chk("b_no_take_cause", dut.csr_cause, 48'd0);
        chk("b_mie_set", {47'b0, dut.csr_status[STATUS_MIE]}, 48'd1);
        wait_halt(20);
        irq = 4'b0000;
        chk("b_pc", dut.pc, 48'd40);
        chk("b_epc", dut.csr_epc, 48'd6);
        chk("b_cause", dut.csr_cause, 48'h8000_0000_0001);
        chk("b_status", dut.csr_status, 48'h20);
        chk("b_enable", dut.csr_irq_enable, 48'd3);
        chk("b_rs_old", dut.RF_D.regs[7], 48'd1);

        // Program C: store/load with address wrap, both branch polarities, ALU ops.
        start_reset();
        load(0, instr_alui_d(1'b0, 3'd2, 3'd0, ALU_ADD, 27'h123));
        load(1, instr_rri(OP_ST, 1'b0, 3'd0, 3'd0, 3'd2, 4'd0, 27'd3));
        load(2, instr_rri(OP_LD, 1'b0, 3'd4, 3'd0, 3'd0, 4'd0, 27'd35));
        load(3, instr_rri(OP_BR, 1'b1, 3'd0, 3'd4, 3'd0, 4'd0, 27'd2));
        load(4, instr_alui_d(1'b0, 3'd3, 3'd0, ALU_ADD, 27'd1));
        load(5, instr_rri(OP_BR, 1'b0, 3'd0, 3'd3, 3'd0, 4'd0, 27'd2));
        load(6, instr_alui_d(1'b0, 3'd3, 3'd0, ALU_ADD, 27'd7));
        load(7, instr_alui_d(1'b1, 3'd1, 3'd0, ALU_ADD, 27'h7FF_FFFF));
        load(8, instr_alui_d(1'b0, 3'd3, 3'd1, ALU_SHR, 27'd40));
        load(9, instr_rri(OP_ALU_R, 1'b0, 3'd6, 3'd0, 3'd2, ALU_SUB, 27'd0));
        load(10, instr_sys(SYS_HALT));
        release_reset();
        wait_halt(30);
        chk("c_dmem3", dut.DMEM.mem[3], 48'h123);
        chk("c_ld_wrap", dut.RF_D.regs[4], 48'h123);
        chk("c_sext", dut.RF_D.regs[1], 48'hFFFF_FFFF_FFFF);
        chk("c_shr_branches", dut.RF_D.regs[3], 48'hFF);
        chk("c_sub_wrap", dut.RF_D.regs[6], 48'hFFFF_FFFF_FEDD);
        chk("c_pc", dut.pc, 48'd10);

        // Program D: undefined opcode at pc=2.
        start_reset();
        load(2, illegal_w);
        load(3, instr_sys(SYS_HALT));
        load(48, instr_sys(SYS_HALT));
        release_reset();
        wait_halt(20);
`ifdef CPU_AD48_TRAP_ILLEGAL_EN
        chk("d_pc", dut.pc, 48'd48);
        chk("d_epc", dut.csr_epc, 48'd2);
        chk("d_cause", dut.csr_cause, 48'd2);
`else
        chk("d_pc", dut.pc, 48'd3);
        chk("d_epc", dut.csr_epc, 48'd0);
        chk("d_cause", dut.csr_cause, 48'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
